// File: rtl/pe_ctrl.sv
// rtl/pe_ctrl.sv - PE load/compute sequencer
//
// Purpose: streams one job of N_WEIGHT weight words followed by N_IFMAP
// ifmap words from a valid/ready source into a processing element's FIFOs,
// waits for the PE to drop Ready (bounded by TIMEOUT), waits CALC_CYCLES
// cycles from that point, then pulses done.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, abort       job request (IDLE only) / synchronous cancel
//   s_valid, s_ready   source handshake; s_data carries weights then ifmap
//   pe_ena             PE enable, high for the whole job
//   pe_weight_wea      PE weight FIFO push (one cycle after each weight beat)
//   pe_ifmap_wea       PE ifmap FIFO push (one cycle after each ifmap beat)
//   pe_psum_wea        PE psum push, tied low
//   pe_value           registered data word for the pushes
//   pe_ready           PE Ready flag
//   busy, done, err    not-IDLE, end-of-job pulse, sticky timeout flag
module pe_ctrl #(
  parameter int N_WEIGHT    = 3,
  parameter int N_IFMAP     = 32,
  parameter int CALC_CYCLES = 96,
  parameter int TIMEOUT     = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        pe_ena,
  output logic        pe_weight_wea,
  output logic        pe_ifmap_wea,
  output logic        pe_psum_wea,
  output logic [31:0] pe_value,
  input  logic        pe_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int MAX1 = (N_IFMAP > CALC_CYCLES) ? N_IFMAP : CALC_CYCLES;
  localparam int MAX2 = (MAX1 > TIMEOUT) ? MAX1 : TIMEOUT;
  localparam int MAX3 = (MAX2 > N_WEIGHT) ? MAX2 : N_WEIGHT;
  localparam int CW   = $clog2(MAX3 + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WLOAD    = 3'd1,
    ILOAD    = 3'd2,
    SETTLE   = 3'd3,
    WAIT_RDY = 3'd4,
    CALC     = 3'd5,
    FIN      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          pe_ena_q, pe_ena_d;
  logic          wwea_q, wwea_d;
  logic          iwea_q, iwea_d;
  logic [31:0]   value_q, value_d;
  logic          beat;

  assign s_ready       = (state_q == WLOAD) || (state_q == ILOAD);
  assign beat          = s_valid && s_ready;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign err           = err_q;
  assign pe_ena        = pe_ena_q;
  assign pe_weight_wea = wwea_q;
  assign pe_ifmap_wea  = iwea_q;
  assign pe_psum_wea   = 1'b0;
  assign pe_value      = value_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wwea_d  = 1'b0;
    iwea_d  = 1'b0;
    value_d = value_q;

    if (abort) begin
      // Cancel wins over start and over a same-cycle beat: the source word
      // is consumed by the handshake but never pushed into the PE.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = WLOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        WLOAD: begin
          if (beat) begin
            wwea_d  = 1'b1;
            value_d = s_data;
            if (cnt_q == CW'(N_WEIGHT - 1)) begin
              state_d = ILOAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ILOAD: begin
          if (beat) begin
            iwea_d  = 1'b1;
            value_d = s_data;
            if (cnt_q == CW'(N_IFMAP - 1)) begin
              state_d = SETTLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SETTLE: begin
          state_d = WAIT_RDY;
          cnt_d   = '0;
        end
        WAIT_RDY: begin
          if (!pe_ready) begin
            // The cycle in which Ready is seen low is the first of the
            // CALC_CYCLES-cycle wait, so the count resumes at 1 in CALC.
            state_d = (CALC_CYCLES <= 1) ? FIN : CALC;
            cnt_d   = CW'(1);
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = FIN;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CALC: begin
          if (cnt_q >= CW'(CALC_CYCLES - 1)) begin
            state_d = FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FIN: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Enable follows the next state so it rises the cycle after start and
    // drops together with the return to IDLE (normal end or abort).
    pe_ena_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pe_ena_q <= 1'b0;
      wwea_q   <= 1'b0;
      iwea_q   <= 1'b0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pe_ena_q <= pe_ena_d;
      wwea_q   <= wwea_d;
      iwea_q   <= iwea_d;
      value_q  <= value_d;
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// tb/tb_pe_ctrl.sv - self-checking bench for pe_ctrl
module tb_pe_ctrl;

  localparam int NW  = 3;
  localparam int NI  = 32;
  localparam int CC  = 96;
  localparam int TO  = 8;
  localparam int TOT = NW + NI;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        pe_ena;
  logic        pe_weight_wea;
  logic        pe_ifmap_wea;
  logic        pe_psum_wea;
  logic [31:0] pe_value;
  logic        pe_ready;
  logic        busy;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  pe_ctrl #(
    .N_WEIGHT   (NW),
    .N_IFMAP    (NI),
    .CALC_CYCLES(CC),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .pe_ena       (pe_ena),
    .pe_weight_wea(pe_weight_wea),
    .pe_ifmap_wea (pe_ifmap_wea),
    .pe_psum_wea  (pe_psum_wea),
    .pe_value     (pe_value),
    .pe_ready     (pe_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk1({tag, ".busy"}, busy, 1'b0);
    chk1({tag, ".s_ready"}, s_ready, 1'b0);
    chk1({tag, ".pe_ena"}, pe_ena, 1'b0);
    chk1({tag, ".wwea"}, pe_weight_wea, 1'b0);
    chk1({tag, ".iwea"}, pe_ifmap_wea, 1'b0);
    chk1({tag, ".psum"}, pe_psum_wea, 1'b0);
    chk1({tag, ".done"}, done, 1'b0);
    chk1({tag, ".err"}, err, exp_err);
  endtask

  // Steps until done rises; n is the number of edges taken. Optionally
  // pulses start when n reaches start_at (the job must ignore it).
  task automatic wait_done(output int n, input int start_at, input string tag);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (n == start_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
      if (done) break;
      chk1({tag, ".wait_wwea"}, pe_weight_wea, 1'b0);
      chk1({tag, ".wait_iwea"}, pe_ifmap_wea, 1'b0);
      chk1({tag, ".wait_s_ready"}, s_ready, 1'b0);
      chk1({tag, ".wait_busy"}, busy, 1'b1);
      chk1({tag, ".wait_err"}, err, 1'b0);
    end
    chk1({tag, ".done_seen"}, done, 1'b1);
  endtask

  // One job. vmode: 0 valid always, 1 toggling, 2 random. seq: data = word
  // index + 1, else random. fall: cycles after SETTLE at which pe_ready
  // drops (0 = never, expect timeout). abort_k: abort on the beat that
  // would carry ifmap word abort_k (-1 = none).
  task automatic run_job(input string tag, input int vmode, input bit seq,
                         input int fall, input int start_at, input int abort_k);
    int          k;
    int          nw;
    int          ni;
    int          n;
    logic        pw;
    logic        pi;
    logic        v;
    logic [31:0] pd;
    logic [31:0] word;
    start = 1'b1;
    step();
    start = 1'b0;
    chk1({tag, ".start_busy"}, busy, 1'b1);
    chk1({tag, ".start_ena"}, pe_ena, 1'b1);
    chk1({tag, ".start_err"}, err, 1'b0);
    k = 0; nw = 0; ni = 0; pw = 1'b0; pi = 1'b0; pd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk1({tag, ".s_ready"}, s_ready, (k < TOT));
      chk1({tag, ".wwea"}, pe_weight_wea, pw);
      chk1({tag, ".iwea"}, pe_ifmap_wea, pi);
      if (pw || pi) chk32({tag, ".value"}, pe_value, pd);
      chk1({tag, ".psum"}, pe_psum_wea, 1'b0);
      chk1({tag, ".load_done"}, done, 1'b0);
      if (pw) nw++;
      if (pi) ni++;
      if (k == TOT) break;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      word    = (seq && v) ? 32'(k + 1) : $urandom;
      s_valid = v;
      s_data  = word;
      if (abort_k >= 0 && v && k == NW + abort_k) begin
        abort = 1'b1;
        step();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk_idle({tag, ".abort"}, 1'b0);
        for (int j = 0; j < 5; j++) begin
          step();
          chk_idle({tag, ".post_abort"}, 1'b0);
        end
        return;
      end
      pw = v && (k < NW);
      pi = v && (k >= NW);
      pd = word;
      if (v) k++;
      step();
    end
    s_valid = 1'b0;
    chk32({tag, ".weight_pushes"}, 32'(nw), 32'(NW));
    chk32({tag, ".ifmap_pushes"}, 32'(ni), 32'(NI));
    if (fall > 0) begin
      for (int i = 0; i < fall; i++) begin
        step();
        chk1({tag, ".settle_wwea"}, pe_weight_wea, 1'b0);
        chk1({tag, ".settle_iwea"}, pe_ifmap_wea, 1'b0);
        chk1({tag, ".settle_done"}, done, 1'b0);
      end
      pe_ready = 1'b0;
      wait_done(n, start_at, tag);
      pe_ready = 1'b1;
      chk32({tag, ".calc_len"}, 32'(n), 32'(CC));
      chk1({tag, ".fin_err"}, err, 1'b0);
    end else begin
      wait_done(n, start_at, tag);
      chk32({tag, ".timeout_len"}, 32'(n), 32'(TO + 1));
      chk1({tag, ".fin_err"}, err, 1'b1);
    end
    chk1({tag, ".fin_busy"}, busy, 1'b1);
    step();
    chk_idle({tag, ".end"}, (fall == 0));
    if (start_at >= 0) begin
      for (int j = 0; j < 10; j++) begin
        step();
        chk_idle({tag, ".no_second_done"}, 1'b0);
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    s_valid  = 1'b1;
    s_data   = 32'hdead_beef;
    pe_ready = 1'b1;

    // Reset with start and s_valid pending: everything stays quiet.
    step();
    step();
    chk_idle("reset", 1'b0);
    chk32("reset.value", pe_value, 32'h0);
    start   = 1'b0;
    s_valid = 1'b0;
    rstn    = 1'b1;
    step();
    chk_idle("post_reset", 1'b0);

    // Abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("abort_start", 1'b0);
    step();
    chk_idle("abort_start2", 1'b0);

    run_job("b2b", 0, 1'b1, 2, -1, -1);
    run_job("bubbles", 1, 1'b1, 2, -1, -1);
    run_job("timeout", 0, 1'b0, 0, -1, -1);
    run_job("clear_err", 0, 1'b0, 3, -1, -1);
    run_job("abort_iload", 0, 1'b0, 2, -1, 10);
    run_job("after_abort", 0, 1'b1, 1, -1, -1);
    run_job("start_in_calc", 0, 1'b0, 3, 40, -1);

    // Reset in the middle of a load abandons the job.
    start = 1'b1;
    step();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    for (int i = 0; i < 6; i++) step();
    #2 rstn = 1'b0;
    #1;
    chk_idle("mid_reset", 1'b0);
    chk32("mid_reset.value", pe_value, 32'h0);
    s_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk_idle("mid_reset_rel", 1'b0);
    run_job("after_reset", 0, 1'b1, 2, -1, -1);

    for (int r = 0; r < 6; r++) begin
      run_job("random", 2, 1'b0, (r == 4) ? 0 : int'($urandom_range(1, TO)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
